// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two masters,
// with a per-port bounded lock for atomic read-modify-write sequences.
//
// state  | meaning
// FREE   | round-robin between A and B using prio
// LOCK_A | only A may be granted; hold counter running
// LOCK_B | only B may be granted; hold counter running
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {FREE, LOCK_A, LOCK_B} state_t;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  state_t     state, state_nxt;
  logic       prio, prio_nxt;   // 0 = A first, 1 = B first
  logic [7:0] cnt, cnt_nxt;
  logic       armed_a, armed_a_nxt;
  logic       armed_b, armed_b_nxt;
  logic       gnt_a, gnt_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FREE;
      prio    <= 1'b0;
      cnt     <= '0;
      armed_a <= 1'b1;
      armed_b <= 1'b1;
    end else begin
      state   <= state_nxt;
      prio    <= prio_nxt;
      cnt     <= cnt_nxt;
      armed_a <= armed_a_nxt;
      armed_b <= armed_b_nxt;
    end
  end

  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    state_nxt   = state;
    prio_nxt    = prio;
    cnt_nxt     = cnt;
    // A disarmed lock comes back once its lock input has been low for a cycle
    armed_a_nxt = armed_a | ~a_lock;
    armed_b_nxt = armed_b | ~b_lock;
    case (state)
      FREE: begin
        if (a_req && (!b_req || !prio)) gnt_a = 1'b1;
        else if (b_req)                 gnt_b = 1'b1;
        if (gnt_a) begin
          prio_nxt = 1'b1;
          if (a_lock && armed_a) begin
            state_nxt = LOCK_A;
            cnt_nxt   = '0;
          end
        end
        if (gnt_b) begin
          prio_nxt = 1'b0;
          if (b_lock && armed_b) begin
            state_nxt = LOCK_B;
            cnt_nxt   = '0;
          end
        end
      end
      LOCK_A: begin
        gnt_a   = a_req;
        cnt_nxt = cnt + 8'd1;
        if (!a_lock) begin
          state_nxt = FREE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = FREE;
          prio_nxt    = 1'b1;
          armed_a_nxt = 1'b0;
        end
      end
      LOCK_B: begin
        gnt_b   = b_req;
        cnt_nxt = cnt + 8'd1;
        if (!b_lock) begin
          state_nxt = FREE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = FREE;
          prio_nxt    = 1'b0;
          armed_b_nxt = 1'b0;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  assign a_gnt = gnt_a & ~reset;
  assign b_gnt = gnt_b & ~reset;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_read  = ~a_we;
      mem_write = a_we;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_read  = ~b_we;
      mem_write = b_we;
    end
  end

  // Registered return path keeps mem_rdata off every output's combinational cone
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata <= mem_rdata;
      if (b_gnt && !b_we) b_rdata <= mem_rdata;
    end
  end

endmodule
